// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: frame width, mode constants and FSM state encoding.
package spi_pkg;

    localparam int SPI_DATA_W = 16;

    // Mode 0: CPOL is the sclk idle level, CPHA selects the sampling edge.
    localparam logic [1:0] SPI_MODE = 2'd0;
    localparam logic       SPI_CPOL = SPI_MODE[1];

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        CS_HOLD,
        FLUSH_LO,
        FLUSH_HI,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick is high on the last of every CLK_DIV clk cycles.
module spi_clk_div #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Restarting on clear keeps every FSM state exactly CLK_DIV cycles long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == TERM);

endmodule

// File: rtl/spi_master.sv
// 16-bit SPI mode-0 master with a valid/ready start handshake, a done pulse and an
// optional sclk pulse with cs_l high after each frame so the slave can reload.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int CLK_DIV     = 1,
    parameter int FLUSH_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              busy,
    output logic              sclk,
    output logic              cs_l,
    output logic              mosi,
    input  logic              miso
);

    localparam int CNT_W    = $clog2(DATA_W + 1);
    localparam bit FLUSH_EN = (FLUSH_PULSE != 0);

    spi_state_t        state, state_next;
    logic [DATA_W-1:0] shift_tx, shift_tx_next;
    logic [DATA_W-1:0] rx_shift, rx_shift_next;
    logic [DATA_W-1:0] rx_data_next;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
    logic              sclk_next, cs_l_next;
    logic              tick, div_clear;

    assign div_clear = (state_next != state);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sclk        <= SPI_CPOL;
            cs_l        <= 1'b1;
            shift_tx    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            bit_cnt     <= '0;
            start_ready <= 1'b0;
        end else begin
            state       <= state_next;
            sclk        <= sclk_next;
            cs_l        <= cs_l_next;
            shift_tx    <= shift_tx_next;
            rx_shift    <= rx_shift_next;
            rx_data     <= rx_data_next;
            bit_cnt     <= bit_cnt_next;
            start_ready <= (state_next == IDLE);
        end
    end

    always_comb begin
        state_next    = state;
        sclk_next     = sclk;
        cs_l_next     = cs_l;
        shift_tx_next = shift_tx;
        rx_shift_next = rx_shift;
        rx_data_next  = rx_data;
        bit_cnt_next  = bit_cnt;

        case (state)
            IDLE: begin
                if (start_valid && start_ready) begin
                    shift_tx_next = tx_data;
                    cs_l_next     = 1'b0;
                    bit_cnt_next  = '0;
                    state_next    = SETUP;
                end
            end
            // miso is captured on the same clk edge that raises sclk, before the slave shifts.
            SETUP, LOW: begin
                if (tick) begin
                    sclk_next     = ~SPI_CPOL;
                    rx_shift_next = {rx_shift[DATA_W-2:0], miso};
                    bit_cnt_next  = bit_cnt + CNT_W'(1);
                    state_next    = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    sclk_next = SPI_CPOL;
                    if (bit_cnt == CNT_W'(DATA_W)) begin
                        state_next = CS_HOLD;
                    end else begin
                        shift_tx_next = {shift_tx[DATA_W-2:0], 1'b0};
                        state_next    = LOW;
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    cs_l_next  = 1'b1;
                    state_next = FLUSH_EN ? FLUSH_LO : DONE;
                end
            end
            FLUSH_LO: begin
                if (tick) begin
                    sclk_next  = ~SPI_CPOL;
                    state_next = FLUSH_HI;
                end
            end
            FLUSH_HI: begin
                if (tick) begin
                    sclk_next  = SPI_CPOL;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // rx_data is published on entry to DONE so it is valid while done is high.
        if (state_next == DONE) begin
            rx_data_next = rx_shift;
        end
    end

    // mosi comes straight from the shift register flop, so it only moves on sclk falls.
    assign mosi = shift_tx[DATA_W-1];
    assign done = (state == DONE);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_master.sv
// Directed bench: three masters (div 1 / flush, div 1 / no flush, div 3 / flush), each
// talking to a behavioural slave that answers 16'hCAFE and reloads on an sclk rise with cs_l high.
module tb_spi_master;

    typedef struct {
        int          ch;
        logic [15:0] rx;
        logic [15:0] slv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_valid [3];
    logic        start_ready [3];
    logic [15:0] tx_data     [3];
    logic [15:0] rx_data     [3];
    logic        done        [3];
    logic        busy        [3];
    logic        sclk        [3];
    logic        cs_l        [3];
    logic        mosi        [3];
    logic        miso        [3];
    logic [15:0] slv_rx      [3];
    int          rise_lo     [3];
    int          rise_hi     [3];
    int          base_lo     [3];
    int          base_hi     [3];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int div_of(input int ch);
        return (ch == 2) ? 3 : 1;
    endfunction

    function automatic int flush_of(input int ch);
        return (ch == 1) ? 0 : 1;
    endfunction

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [15:0] s_tx;
        logic [15:0] s_rx;
        int          n_lo = 0;
        int          n_hi = 0;

        spi_master #(
            .DATA_W      (16),
            .CLK_DIV     ((i == 2) ? 3 : 1),
            .FLUSH_PULSE ((i == 1) ? 0 : 1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start_valid (start_valid[i]),
            .start_ready (start_ready[i]),
            .tx_data     (tx_data[i]),
            .rx_data     (rx_data[i]),
            .done        (done[i]),
            .busy        (busy[i]),
            .sclk        (sclk[i]),
            .cs_l        (cs_l[i]),
            .mosi        (mosi[i]),
            .miso        (miso[i])
        );

        // Slave shifts after each sclk rise; a rise with cs_l high reloads its response.
        always @(posedge sclk[i] or posedge rst) begin
            if (rst) begin
                s_tx <= 16'hCAFE;
                s_rx <= 16'h0000;
            end else if (!cs_l[i]) begin
                s_rx <= {s_rx[14:0], mosi[i]};
                s_tx <= {s_tx[14:0], 1'b0};
            end else begin
                s_tx <= 16'hCAFE;
            end
        end

        always @(posedge sclk[i]) begin
            if (cs_l[i]) n_hi <= n_hi + 1;
            else         n_lo <= n_lo + 1;
        end

        assign miso[i]    = s_tx[15];
        assign slv_rx[i]  = s_rx;
        assign rise_lo[i] = n_lo;
        assign rise_hi[i] = n_hi;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic markAccept(input int ch);
        base_lo[ch] = rise_lo[ch];
        base_hi[ch] = rise_hi[ch];
    endtask

    // Returns just after the accept edge E0.
    task automatic applyStimulus(input int ch, input logic [15:0] data, input logic [15:0] rx_exp);
        @(negedge clk);
        start_valid[ch] = 1'b1;
        tx_data[ch]     = data;
        for (int w = 0; w < 100 && !start_ready[ch]; w++) @(negedge clk);
        checkOutput($sformatf("ch%0d_ready_at_start", ch), start_ready[ch], 1);
        exp_q.push_back('{ch: ch, rx: rx_exp, slv: data});
        @(posedge clk);
        markAccept(ch);
        #1 start_valid[ch] = 1'b0;
    endtask

    // Sample m at the negedge following edge E0+m; measures cs_l window and sclk phase lengths.
    task automatic collectFrame(input int ch);
        int   h, k_exp, k, cs_low, runs, bad, run_len;
        logic prev_s;
        bit   found;
        exp_t e;
        h       = div_of(ch);
        k_exp   = 33 * h + (flush_of(ch) != 0 ? 2 * h : 0);
        k       = -1;
        cs_low  = 0;
        runs    = 0;
        bad     = 0;
        run_len = 0;
        prev_s  = 1'b0;
        found   = 1'b0;
        for (int m = 0; m < 200 * h && !found; m++) begin
            @(negedge clk);
            if (!cs_l[ch]) begin
                cs_low++;
                if (run_len > 0 && sclk[ch] != prev_s) begin
                    runs++;
                    if (run_len != h) bad++;
                    run_len = 1;
                end else begin
                    run_len++;
                end
                prev_s = sclk[ch];
            end else if (run_len > 0) begin
                runs++;
                if (run_len != h) bad++;
                run_len = 0;
            end
            if (done[ch]) begin
                found = 1'b1;
                k     = m;
            end
        end
        checkOutput($sformatf("ch%0d_done_seen", ch), found, 1);
        checkOutput($sformatf("ch%0d_sb_pending", ch), exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("ch%0d_rx_data", ch), rx_data[ch], e.rx);
            checkOutput($sformatf("ch%0d_slave_rx", ch), slv_rx[ch], e.slv);
        end
        checkOutput($sformatf("ch%0d_done_latency", ch), k, k_exp);
        checkOutput($sformatf("ch%0d_rises_cs_low", ch), rise_lo[ch] - base_lo[ch], 16);
        checkOutput($sformatf("ch%0d_rises_cs_high", ch), rise_hi[ch] - base_hi[ch], flush_of(ch));
        checkOutput($sformatf("ch%0d_cs_low_cycles", ch), cs_low, 33 * h);
        checkOutput($sformatf("ch%0d_sclk_phases", ch), runs, 33);
        checkOutput($sformatf("ch%0d_bad_phase_len", ch), bad, 0);
        checkOutput($sformatf("ch%0d_busy_at_done", ch), busy[ch], 1);
        checkOutput($sformatf("ch%0d_ready_at_done", ch), start_ready[ch], 0);
        @(negedge clk);
        checkOutput($sformatf("ch%0d_done_one_cycle", ch), done[ch], 0);
        checkOutput($sformatf("ch%0d_ready_after_done", ch), start_ready[ch], 1);
        checkOutput($sformatf("ch%0d_busy_after_done", ch), busy[ch], 0);
        if (found) checkOutput($sformatf("ch%0d_rx_hold", ch), rx_data[ch], e.rx);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   ready_seen, done_cnt;
        bit   found;
        exp_t e;

        for (int c = 0; c < 3; c++) begin
            start_valid[c] = 1'b0;
            tx_data[c]     = 16'h0000;
        end
        #1 rst = 1'b1;

        // Power-up reset values.
        repeat (3) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("ch%0d_rst_sclk", c), sclk[c], 0);
            checkOutput($sformatf("ch%0d_rst_cs_l", c), cs_l[c], 1);
            checkOutput($sformatf("ch%0d_rst_mosi", c), mosi[c], 0);
            checkOutput($sformatf("ch%0d_rst_rx_data", c), rx_data[c], 0);
            checkOutput($sformatf("ch%0d_rst_done", c), done[c], 0);
            checkOutput($sformatf("ch%0d_rst_busy", c), busy[c], 0);
            checkOutput($sformatf("ch%0d_rst_ready", c), start_ready[c], 0);
        end
        rst = 1'b0;
        #1 checkOutput("ready_before_first_edge", start_ready[0], 0);
        @(negedge clk);
        for (int c = 0; c < 3; c++) checkOutput($sformatf("ch%0d_ready_after_rst", c), start_ready[c], 1);

        // Back-to-back frames with flush: slave reloads between them.
        applyStimulus(0, 16'h1234, 16'hCAFE);
        collectFrame(0);
        applyStimulus(0, 16'hA5A5, 16'hCAFE);
        collectFrame(0);

        // Without flush the slave is drained after the first frame.
        applyStimulus(1, 16'h1234, 16'hCAFE);
        collectFrame(1);
        applyStimulus(1, 16'hA5A5, 16'h0000);
        collectFrame(1);

        // Divided clock.
        applyStimulus(2, 16'h1234, 16'hCAFE);
        collectFrame(2);

        // start_valid held through the frame with tx_data churning.
        @(negedge clk);
        start_valid[0] = 1'b1;
        tx_data[0]     = 16'h3C5A;
        checkOutput("hold_ready_idle", start_ready[0], 1);
        exp_q.push_back('{ch: 0, rx: 16'hCAFE, slv: 16'h3C5A});
        @(posedge clk);
        ready_seen = 0;
        found      = 1'b0;
        for (int m = 0; m < 200 && !found; m++) begin
            @(negedge clk);
            if (start_ready[0]) ready_seen++;
            if (done[0]) found = 1'b1;
            else tx_data[0] = 16'($urandom);
        end
        tx_data[0] = 16'h0F0F;
        checkOutput("hold_done_seen", found, 1);
        checkOutput("hold_ready_during_frame", ready_seen, 0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("hold_rx_data", rx_data[0], e.rx);
            checkOutput("hold_slave_rx", slv_rx[0], e.slv);
        end
        @(negedge clk);
        checkOutput("hold_ready_after_done", start_ready[0], 1);
        exp_q.push_back('{ch: 0, rx: 16'hCAFE, slv: 16'h0F0F});
        @(posedge clk);
        markAccept(0);
        #1 start_valid[0] = 1'b0;
        collectFrame(0);

        // Reset in the middle of a frame.
        applyStimulus(0, 16'h5555, 16'hCAFE);
        found = 1'b0;
        for (int m = 0; m < 100 && !found; m++) begin
            @(negedge clk);
            if (rise_lo[0] - base_lo[0] >= 5) found = 1'b1;
        end
        checkOutput("abort_rises", rise_lo[0] - base_lo[0], 5);
        checkOutput("abort_sclk_high", sclk[0], 1);
        rst = 1'b1;
        #1;
        checkOutput("abort_cs_l", cs_l[0], 1);
        checkOutput("abort_sclk", sclk[0], 0);
        checkOutput("abort_busy", busy[0], 0);
        checkOutput("abort_ready", start_ready[0], 0);
        checkOutput("abort_mosi", mosi[0], 0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int m = 0; m < 40; m++) begin
            @(negedge clk);
            if (done[0]) done_cnt++;
        end
        checkOutput("abort_no_done", done_cnt, 0);
        checkOutput("abort_ready_back", start_ready[0], 1);
        applyStimulus(0, 16'h1234, 16'hCAFE);
        collectFrame(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- 16-bit SPI mode-0 master in the system clock domain. It drives sclk, cs_l and mosi into the SPI_Slave and captures its miso response.
- The host side uses a valid/ready start handshake and a one-cycle done pulse that returns the received word.
- An optional flush pulse is issued after each frame. It gives the slave one sclk rising edge while cs_l is high, so the slave reloads its response word before the next frame.

Parameters:
- DATA_W, 16, frame width in bits, MSB first. Only 16 is verified.
- CLK_DIV, 1, number of clk cycles per sclk half-period. Must be >= 1.
- FLUSH_PULSE, 1, 1 = emit one sclk pulse with cs_l high after each frame; 0 = no pulse.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  host requests a transfer.
- start_ready  out  1  master is idle and can accept a transfer.
- tx_data  in  DATA_W  word to send; sampled only on the start handshake.
- rx_data  out  DATA_W  received word; valid from done onward, held until the next done.
- done  out  1  one-cycle pulse marking the end of a transfer.
- busy  out  1  high from the accept edge until the cycle after done.
- sclk  out  1  SPI clock, idles low (CPOL=0). Registered.
- cs_l  out  1  active-low chip select, idles high. Registered.
- mosi  out  1  serial data out. Registered; changes only while sclk is low.
- miso  in  1  serial data in from the slave.

Behaviour:
- Reset (asynchronous, immediate): sclk=0, cs_l=1, mosi=0, rx_data=0, done=0, busy=0, start_ready=0 while rst is high.
  - start_ready=1 from the first clk edge after rst deasserts.
  - Reset mid-frame aborts the frame at once: cs_l goes high and sclk low with no glitch beyond the reset itself. No done pulse is produced.
- Handshake: a transfer is accepted at edge E0 when start_valid && start_ready.
  - start_ready=0 from E0 until the cycle after done.
  - start_valid while busy is ignored; no queuing.
- Half-period tick: a counter counts CLK_DIV cycles; its terminal count advances the FSM. The counter restarts on each state change. H = CLK_DIV.
- States:
  - IDLE: on accept, load shift_tx=tx_data, cs_l=0, mosi=tx_data[MSB], bit_cnt=0; go to SETUP.
  - SETUP: sclk low for H. On tick: sclk=1, rx_shift={rx_shift, miso}, bit_cnt++; go to HIGH.
  - HIGH: on tick: sclk=0. If bit_cnt==DATA_W go to CS_HOLD. Otherwise shift_tx<<=1, mosi=next bit, go to LOW.
  - LOW: on tick: sclk=1, sample miso, bit_cnt++; go to HIGH.
  - CS_HOLD: sclk low for H. On tick: cs_l=1; go to FLUSH_LO if FLUSH_PULSE, else DONE.
  - FLUSH_LO: on tick: sclk=1; go to FLUSH_HI.
  - FLUSH_HI: on tick: sclk=0; go to DONE.
  - DONE: one cycle. done=1, rx_data=rx_shift; then go to IDLE.
- Sampling rule: miso is sampled at the same clk edge that raises sclk. The slave shifts only after the sclk rise, so the pre-shift bit is captured.
- Edge timing from E0:
  - cs_l falls at E0.
  - Rising edge k occurs at E0+(2k-1)H.
  - The last falling edge occurs at E0+32H.
  - cs_l rises at E0+33H.
  - done is high for the cycle after edge E0+35H (FLUSH_PULSE=1) or E0+33H (FLUSH_PULSE=0).
  - start_ready returns one cycle after done.
- mosi holds its final bit after the frame until the next accept.

Decomposition:
- Shared package spi_pkg: DATA_W default, the state enum (IDLE, SETUP, HIGH, LOW, CS_HOLD, FLUSH_LO, FLUSH_HI, DONE) and SPI mode constants.
- One sub-module, spi_clk_div: the half-period tick generator with inputs clk, rst, clear and output tick, parameterised by CLK_DIV.

Test Plan:
- Power-up, then send 16'h1234 to SPI_Slave with CLK_DIV=1 -> rx_data=16'hCAFE at done, slave rx_shift=16'h1234, exactly 16 sclk rises while cs_l is low, done one cycle after edge E0+35.
- Back-to-back 16'h1234 then 16'hA5A5 with FLUSH_PULSE=1 -> both return 16'hCAFE, with one sclk pulse while cs_l is high between the frames.
- Same two transfers with FLUSH_PULSE=0 -> first returns 16'hCAFE, second returns 16'h0000.
- CLK_DIV=3 -> each sclk high/low phase lasts exactly 3 clk cycles, cs_l low for 99 cycles, done one cycle after edge E0+105.
- Assert rst after 5 sclk rises -> cs_l=1, sclk=0 and busy=0 immediately, no done pulse; next transfer completes normally with rx_data=16'hCAFE.
- Hold start_valid high through the whole transfer with tx_data changing mid-frame -> exactly one accept per idle period, mosi carries the word sampled at E0, start_ready low until after done.
